// File: rtl/result_ascii_tx.sv
// ---------------------------------------------------------------------------
// result_ascii_tx
//
// Formats a 32-bit ALU result as decimal ASCII and feeds it byte by byte to
// a UART transmitter: an optional '-' sign, the digits with leading zeros
// suppressed (zero itself is sent as "0"), then the DELIM terminator.
//
// The binary value is converted to ten BCD digits with a serial double-dabble
// (32 cycles). Each byte is then presented on d_out together with a
// one-cycle tx_start pulse. The block waits for a rising edge of tx_done
// before presenting the next byte.
//
// Parameters
//   DELIM    terminator byte sent after the last digit
//   SIGNED   1: result is two's complement, 0: result is unsigned
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     one-cycle request to send result (honoured only when idle)
//   result    value to format, latched when start is accepted
//   tx_done   UART byte-complete flag, level or pulse; only rising edges count
//   d_out     ASCII byte for the UART
//   tx_start  one-cycle pulse requesting transmission of d_out
//   busy      high from the accepted start until the final handshake
//   done      one-cycle pulse once the terminator has been transmitted
// ---------------------------------------------------------------------------
module result_ascii_tx #(
  parameter logic [7:0] DELIM  = 8'h20,
  parameter bit         SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  input  logic        tx_done,
  output logic [7:0]  d_out,
  output logic        tx_start,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    IDLE,
    CONV,
    SIGN,
    SKIP,
    SEND,
    WAIT,
    TERM,
    WAITT,
    FIN
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [39:0] bcd_reg;        // ten BCD digits, digit 9 is most significant
  logic [31:0] bin_reg;        // binary magnitude being shifted into bcd_reg
  logic [4:0]  cnt_reg;        // conversion bit counter
  logic [3:0]  pos_reg;        // digit currently being skipped or sent
  logic        neg_reg;
  logic        from_sign_reg;  // the pending handshake belongs to the '-' byte
  logic        tx_done_prev_reg;
  logic [7:0]  byte_hold_reg;  // last byte launched, kept on d_out while waiting

  logic [31:0] magnitude;
  logic        result_neg;
  logic [39:0] bcd_adj;
  logic [3:0]  digit [10];
  logic [3:0]  cur_digit;
  logic        skip_digit;
  logic        tx_rise;
  logic [7:0]  cur_byte;

  // Sign and magnitude of the incoming value. For 0x80000000 the two's
  // complement wraps back to 0x80000000, which read as unsigned is exactly
  // the wanted magnitude 2147483648.
  assign result_neg = SIGNED & result[31];
  assign magnitude  = result_neg ? (~result + 32'd1) : result;

  // Double-dabble correction: every digit of 5 or more gets +3 before the
  // shift so that doubling carries correctly into the next decade.
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_digit
      assign digit[gi] = bcd_reg[gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  (bcd_reg[gi*4 +: 4] + 4'd3) :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign cur_digit  = digit[pos_reg];
  // Position 0 is never skipped, so a zero value still produces "0".
  assign skip_digit = (pos_reg != 4'd0) && (cur_digit == 4'd0);
  // A level-style tx_done held high produces only one rise.
  assign tx_rise    = tx_done & ~tx_done_prev_reg;

  // Byte presented this cycle; in every non-launching state d_out keeps
  // showing the last launched byte so it stays stable through WAIT.
  always_comb begin
    cur_byte = byte_hold_reg;
    case (state_reg)
      SIGN:    cur_byte = 8'h2D;
      SEND:    cur_byte = 8'h30 + {4'd0, cur_digit};
      TERM:    cur_byte = DELIM;
      default: cur_byte = byte_hold_reg;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CONV;
        end
      end
      CONV: begin
        if (cnt_reg == 5'd31) begin
          state_next = neg_reg ? SIGN : SKIP;
        end
      end
      SIGN: begin
        state_next = WAIT;
      end
      SKIP: begin
        if (!skip_digit) begin
          state_next = SEND;
        end
      end
      SEND: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (tx_rise) begin
          if (from_sign_reg) begin
            state_next = SKIP;
          end else if (pos_reg == 4'd0) begin
            state_next = TERM;
          end else begin
            state_next = SEND;
          end
        end
      end
      TERM: begin
        state_next = WAITT;
      end
      WAITT: begin
        if (tx_rise) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs (Moore). Each launching state lasts exactly one cycle and
  // is always followed by a waiting state, so tx_start can never be high on
  // two consecutive cycles.
  // -------------------------------------------------------------------------
  always_comb begin
    d_out    = cur_byte;
    tx_start = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
      end
      SIGN, SEND, TERM: begin
        tx_start = 1'b1;
      end
      FIN: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        tx_start = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: conversion registers, digit pointer and handshake history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_reg          <= '0;
      bin_reg          <= '0;
      cnt_reg          <= '0;
      pos_reg          <= '0;
      neg_reg          <= 1'b0;
      from_sign_reg    <= 1'b0;
      tx_done_prev_reg <= 1'b0;
      byte_hold_reg    <= '0;
    end else begin
      tx_done_prev_reg <= tx_done;
      if (tx_start) begin
        byte_hold_reg <= cur_byte;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            bin_reg       <= magnitude;
            neg_reg       <= result_neg;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            pos_reg       <= 4'd9;
            from_sign_reg <= 1'b0;
          end
        end
        CONV: begin
          bcd_reg <= {bcd_adj[38:0], bin_reg[31]};
          bin_reg <= {bin_reg[30:0], 1'b0};
          cnt_reg <= cnt_reg + 5'd1;
        end
        SIGN: begin
          from_sign_reg <= 1'b1;
        end
        SKIP: begin
          if (skip_digit) begin
            pos_reg <= pos_reg - 4'd1;
          end
        end
        WAIT: begin
          if (tx_rise) begin
            if (from_sign_reg) begin
              from_sign_reg <= 1'b0;
            end else if (pos_reg != 4'd0) begin
              pos_reg <= pos_reg - 4'd1;
            end
          end
        end
        default: begin
          cnt_reg <= cnt_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
// ---------------------------------------------------------------------------
// tb_result_ascii_tx
//
// Two instances: one with SIGNED=1 and one with SIGNED=0, sharing result,
// reset and tx_done; sel steers start to one of them and picks whose outputs
// are observed. A responder process emulates the UART: it answers every
// observed tx_start with a tx_done high period of hold_len cycles, starting
// resp_delay cycles after the request. Expected byte streams and first-byte
// latency come from a decimal-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_result_ascii_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] result = '0;
  logic        tx_done = 1'b0;
  logic        sel = 1'b0;

  logic [7:0]  d_out_s, d_out_u, d_out_m;
  logic        tx_start_s, tx_start_u, tx_start_m;
  logic        busy_s, busy_u, busy_m;
  logic        done_s, done_u, done_m;
  logic        start_s, start_u;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          resp_delay = 5;
  int          hold_len = 1;
  int          first_cyc = -1;
  int          exp_lat = 0;
  int          req_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  last_byte = '0;
  logic        prev_start = 1'b0;

  assign start_s    = start & ~sel;
  assign start_u    = start & sel;
  assign d_out_m    = sel ? d_out_u : d_out_s;
  assign tx_start_m = sel ? tx_start_u : tx_start_s;
  assign busy_m     = sel ? busy_u : busy_s;
  assign done_m     = sel ? done_u : done_s;

  result_ascii_tx #(.DELIM(8'h20), .SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .result(result),
    .tx_done(tx_done), .d_out(d_out_s), .tx_start(tx_start_s),
    .busy(busy_s), .done(done_s)
  );

  result_ascii_tx #(.DELIM(8'h20), .SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(start_u), .result(result),
    .tx_done(tx_done), .d_out(d_out_u), .tx_start(tx_start_u),
    .busy(busy_u), .done(done_u)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte monitor: records launched bytes, checks pulse spacing and that
  // d_out stays on the last launched byte between launches.
  always @(negedge clk) begin
    if (tx_start_m) begin
      n_assert++;
      assert (prev_start == 1'b0) else begin
        n_fail++;
        $error("FAIL tx_start_back_to_back observed=1 expected=0");
      end
      if (got_q.size() == 0) first_cyc = cyc;
      got_q.push_back(d_out_m);
      last_byte = d_out_m;
      req_q.push_back(cyc);
    end else if (busy_m && got_q.size() > 0) begin
      check("d_out_stable", d_out_m, last_byte);
    end
    prev_start = tx_start_m;
  end

  // UART emulation
  always begin
    @(negedge clk);
    if (req_q.size() > 0 && cyc >= req_q[0] + resp_delay) begin
      tx_done = 1'b1;
      repeat (hold_len) @(negedge clk);
      tx_done = 1'b0;
      if (req_q.size() > 0) void'(req_q.pop_front());
    end
  end

  // Reference: sign, decimal digits by repeated division, terminator.
  // First tx_start is seen 33 cycles after the start edge (1 accept + 32
  // conversion) for a '-', otherwise one more cycle per skipped leading zero
  // plus the SKIP cycle that finds the first digit to send.
  task automatic build_expected(input bit signed_mode, input logic [31:0] v);
    longint unsigned m;
    bit              neg;
    logic [7:0]      digs[$];
    neg = signed_mode && v[31];
    m = neg ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
    exp_q.delete();
    if (neg) exp_q.push_back(8'h2D);
    do begin
      digs.push_front(8'h30 + 8'(m % 10));
      m = m / 10;
    end while (m != 0);
    foreach (digs[i]) exp_q.push_back(digs[i]);
    exp_q.push_back(8'h20);
    exp_lat = neg ? 33 : (44 - digs.size());
  endtask

  task automatic run_txn(input bit s, input logic [31:0] val, input bit poke);
    int n;
    int done_cnt;
    int t0;
    build_expected(!s, val);
    sel = s;
    result = val;
    got_q.delete();
    first_cyc = -1;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_after_start_%0h", val), busy_m, 1'b1);
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
      if (done_m) done_cnt++;
      start = poke && (done_cnt == 0) && (n % 9 == 4);
      if (start) result = $urandom;
    end
    start = 1'b0;
    check("done_timeout", (n < 4000), 1'b1);
    check("busy_at_done", busy_m, 1'b0);
    repeat (4) begin
      @(negedge clk);
      if (done_m) done_cnt++;
    end
    check("done_pulse_count", done_cnt, 1);
    check($sformatf("byte_count_%0h", val), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("byte%0d_%0h", i, val), got_q[i], exp_q[i]);
    end
    check($sformatf("first_tx_latency_%0h", val), first_cyc - t0, exp_lat);
    $display("txn sel=%0d result=%08h bytes=%0d latency=%0d", s, val, got_q.size(), first_cyc - t0);
  endtask

  initial begin
    int n;
    bit s;
    logic [31:0] v;

    repeat (3) @(negedge clk);
    check("reset_d_out", d_out_m, 8'h00);
    check("reset_tx_start", tx_start_m, 1'b0);
    check("reset_busy", busy_m, 1'b0);
    check("reset_done", done_m, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_txn(1'b0, 32'd123, 1'b0);
    run_txn(1'b0, 32'd0, 1'b0);
    run_txn(1'b0, 32'hFFFFFFFB, 1'b0);
    run_txn(1'b0, 32'h80000000, 1'b0);
    run_txn(1'b1, 32'hFFFFFFFF, 1'b0);
    run_txn(1'b1, 32'h80000000, 1'b0);

    // Level-style tx_done held 20 cycles per byte
    hold_len = 20;
    run_txn(1'b0, 32'hFFFF_FF9C, 1'b0);
    run_txn(1'b1, $urandom, 1'b0);
    hold_len = 1;

    // start re-asserted while busy
    run_txn(1'b0, 32'd4096, 1'b1);

    // Reset in WAIT after the second byte
    sel = 1'b0;
    result = 32'd98765;
    got_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_timeout", (n < 2000), 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_d_out", d_out_m, 8'h00);
    check("midreset_tx_start", tx_start_m, 1'b0);
    check("midreset_busy", busy_m, 1'b0);
    check("midreset_done", done_m, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("no_bytes_after_reset", got_q.size(), 2);
    check("idle_after_reset", busy_m, 1'b0);
    req_q.delete();
    run_txn(1'b0, 32'd7, 1'b0);

    // Randomized transactions
    for (int k = 0; k < 8; k++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        default: v = {1'b1, 31'($urandom)};
      endcase
      resp_delay = $urandom_range(1, 8);
      hold_len = ($urandom_range(0, 3) == 0) ? 20 : $urandom_range(1, 4);
      run_txn(s, v, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
